script_player: RTL and testbench
================================

// Module: script_player
// PURPOSE
//  - Upstream feeder for the text view: plays a fixed demo script of 8-bit token codes, one token per clk_1s tick.
//  - Presents each token as data[5:0] (glyph codes 1..60) or a cmd[7:0] pulse pattern (bksp/enter/up/down).
//  - Crosses to the 50 MHz consumer with a toggle req/ack handshake; the downstream edge-detector turns the req toggle into a one-cycle strobe.
// PARAMETERS
//  - SCRIPT_LEN   32  number of script table entries; idx wraps/ends at SCRIPT_LEN-1
//  - GAP_TICKS    0   idle ticks inserted after each acknowledged token (0 = none)
//  - ACK_TIMEOUT  4   ticks allowed in WAIT_ACK before err is raised
// PORTS
//  - clk_1s    in   1  1 Hz tick clock
//  - reset     in   1  synchronous, active-high
//  - start     in   1  level; sampled in IDLE/DONE to begin playback from idx 0
//  - pause     in   1  level; freezes LOAD/GAP progress while high
//  - ack_tgl   in   1  consumer ack toggle (async; 2-flop synchronised inside)
//  - req_tgl   out  1  flips once per new token presented
//  - tok_data  out  6  glyph code of current token, 0 when token is a command
//  - tok_cmd   out  8  [0]=busy [1]=pg_up [2]=pg_down [3]=backspace [4]=breakline [7:5]=0
//  - busy      out  1  high in LOAD/WAIT_ACK/GAP; mirrored on tok_cmd[0]
//  - done      out  1  high in DONE
//  - err       out  1  sticky ack-timeout flag; cleared by reset or start
//  - idx       out  5  current table index ($clog2(SCRIPT_LEN))
// BEHAVIOUR
//  - Reset (clk_1s edge with reset=1): state=IDLE, all outputs 0, req_tgl=0, sync flops 0; consumer must reset its ack to 0 too.
//  - Table (entries beyond listed = 61): 53 9 4 59 56 59 58 24 60 24 66 61  ("$id = λx.x", enter, end).
//  - Token decode: 1..60 -> tok_data=code, tok_cmd[4:1]=0; 65->bksp bit3; 66->breakline bit4; 67->pg_up bit1; 68->pg_down bit2; any other code (0,62..64,69..255) skipped (idx+1, no req flip).
//  - IDLE: start=1 -> LOAD, idx=0, err=0. DONE: start=1 -> same as IDLE.
//  - LOAD (pause=0): code 61 -> DONE (tok_* cleared); valid token -> drive tok_data/tok_cmd, flip req_tgl, tmo=0 -> WAIT_ACK. Latency start->first req flip: 2 ticks.
//  - WAIT_ACK: ack_sync==req_tgl -> clear tok_cmd[4:1], idx+1, -> GAP if GAP_TICKS>0 else LOAD. Else tmo+1; tmo==ACK_TIMEOUT-1 -> err=1, -> DONE. pause ignored here.
//  - GAP: count GAP_TICKS ticks (held while pause=1), then LOAD.
//  - idx==SCRIPT_LEN-1 acknowledged with no 61 seen -> DONE (no wrap without macro).
//  - start while busy: ignored. reset wins over everything same edge.
//  - tok_data/tok_cmd stable from req flip until ack observed; never change in WAIT_ACK.
// CONFIGURATION
//  - SCRIPT_LOOP_EN defined: code 61 or end of table -> idx=0, LOAD (never DONE except on err); done stays 0.
//  - SCRIPT_LOOP_EN undefined: behaviour as above, halts in DONE.
// TESTING
//  - reset 2 ticks -> req_tgl=0, busy=0, done=0, tok_data=0, tok_cmd=0, idx=0.
//  - start=1, ack echoes req 1 tick later -> tok_data 53,9,4,59,56,59,58,24,60,24 in order, then tok_cmd=8'h11 at idx 10, then done=1 after 11 req flips.
//  - start, never ack, ACK_TIMEOUT=4 -> err=1, state DONE 4 ticks after first req flip; req_tgl flipped exactly once.
//  - pause=1 during GAP (GAP_TICKS=2) for 3 ticks -> next req flip delayed by exactly 3 ticks.
//  - reset asserted in WAIT_ACK at idx 5 -> next tick all outputs 0, idx=0, IDLE; start replays from code 53.
//  - with SCRIPT_LOOP_EN: after idx 10 ack -> idx 0, tok_data=53 re-presented; done never set.

Source files
------------

// File: rtl/script_player.sv
// script_player: plays a fixed token script, one token per tick, over a toggle req/ack link.
// Optional SCRIPT_LOOP_EN: restart at idx 0 instead of halting in DONE.
module script_player #(
  parameter int SCRIPT_LEN  = 32,
  parameter int GAP_TICKS   = 0,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                          clk_1s,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          ack_tgl,
  output logic                          req_tgl,
  output logic [5:0]                    tok_data,
  output logic [7:0]                    tok_cmd,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(SCRIPT_LEN)-1:0] idx
);

  localparam int IW = $clog2(SCRIPT_LEN);
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(SCRIPT_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    C_END    = 8'd61;

`ifdef SCRIPT_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  function automatic logic [7:0] rom(input logic [IW-1:0] i);
    logic [7:0] c;
    case (int'(i))
      0:       c = 8'd53;
      1:       c = 8'd9;
      2:       c = 8'd4;
      3:       c = 8'd59;
      4:       c = 8'd56;
      5:       c = 8'd59;
      6:       c = 8'd58;
      7:       c = 8'd24;
      8:       c = 8'd60;
      9:       c = 8'd24;
      10:      c = 8'd66;
      default: c = C_END;
    endcase
    return c;
  endfunction

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          req_q, req_d;
  logic [5:0]    data_q, data_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;
  logic          ack_s1_q, ack_s1_d;
  logic          ack_s2_q, ack_s2_d;

  logic [7:0]    code;
  logic [3:0]    cmd_bits;
  logic          is_end;
  logic          is_glyph;
  logic          is_cmd;
  logic          at_last;
  logic          ack_seen;
  logic [IW-1:0] idx_nx;
  state_e        adv_state;

  always_ff @(posedge clk_1s) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      req_q    <= 1'b0;
      data_q   <= '0;
      cmd_q    <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      err_q    <= 1'b0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      req_q    <= req_d;
      data_q   <= data_d;
      cmd_q    <= cmd_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
      ack_s1_q <= ack_s1_d;
      ack_s2_q <= ack_s2_d;
    end
  end

  // cmd_q holds tok_cmd[4:1] = {breakline, backspace, pg_down, pg_up}
  always_comb begin
    code     = rom(idx_q);
    is_end   = (code == C_END);
    is_glyph = (code >= 8'd1) && (code <= 8'd60);
    is_cmd   = (code >= 8'd65) && (code <= 8'd68);
    cmd_bits = 4'b0000;
    case (code)
      8'd65:   cmd_bits = 4'b0100;
      8'd66:   cmd_bits = 4'b1000;
      8'd67:   cmd_bits = 4'b0001;
      8'd68:   cmd_bits = 4'b0010;
      default: cmd_bits = 4'b0000;
    endcase
    at_last   = (idx_q == IDX_LAST);
    ack_seen  = (ack_s2_q == req_q);
    idx_nx    = at_last ? '0 : idx_q + IW'(1);
    adv_state = (GAP_TICKS > 0) ? S_GAP : S_LOAD;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    req_d    = req_q;
    data_d   = data_q;
    cmd_d    = cmd_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    err_d    = err_q;
    ack_s1_d = ack_tgl;
    ack_s2_d = ack_s1_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
          data_d  = '0;
          cmd_d   = '0;
        end
      end
      S_LOAD: begin
        if (!pause) begin
          unique case (1'b1)
            is_end: begin
              if (LOOP) begin
                idx_d = '0;
              end else begin
                state_d = S_DONE;
                data_d  = '0;
                cmd_d   = '0;
              end
            end
            is_glyph: begin
              data_d  = code[5:0];
              cmd_d   = '0;
              req_d   = ~req_q;
              tmo_d   = '0;
              state_d = S_WAIT;
            end
            is_cmd: begin
              data_d  = '0;
              cmd_d   = cmd_bits;
              req_d   = ~req_q;
              tmo_d   = '0;
              state_d = S_WAIT;
            end
            default: begin
              if (at_last && !LOOP) begin
                state_d = S_DONE;
                data_d  = '0;
                cmd_d   = '0;
              end else begin
                idx_d = idx_nx;
              end
            end
          endcase
        end
      end
      S_WAIT: begin
        if (ack_seen) begin
          cmd_d = '0;
          if (at_last && !LOOP) begin
            state_d = S_DONE;
            data_d  = '0;
          end else begin
            idx_d   = idx_nx;
            gap_d   = '0;
            state_d = adv_state;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          data_d  = '0;
          cmd_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP: begin
        if (!pause) begin
          if (gap_q == GAP_LAST) begin
            state_d = S_LOAD;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == S_LOAD) ||
               (state_q == S_WAIT) ||
               (state_q == S_GAP);
    done     = (state_q == S_DONE) && !LOOP;
    err      = err_q;
    req_tgl  = req_q;
    tok_data = data_q;
    tok_cmd  = {3'b000, cmd_q, busy};
    idx      = idx_q;
  end

endmodule

// File: tb/tb_script_player.sv
// tb_script_player: directed checks of script playback, timeout, reset and gap pause.
module tb_script_player;

  logic       clk_1s = 1'b0;
  logic       reset  = 1'b1;

  logic       start0 = 1'b0;
  logic       pause0 = 1'b0;
  logic       ack0   = 1'b0;
  logic       req0;
  logic [5:0] data0;
  logic [7:0] cmd0;
  logic       busy0;
  logic       done0;
  logic       err0;
  logic [4:0] idx0;

  logic       startg = 1'b0;
  logic       pauseg = 1'b0;
  logic       ackg   = 1'b0;
  logic       reqg;
  logic [5:0] datag;
  logic [7:0] cmdg;
  logic       busyg;
  logic       doneg;
  logic       errg;
  logic [4:0] idxg;

  always #5 clk_1s = ~clk_1s;

  script_player #(
    .SCRIPT_LEN (32),
    .GAP_TICKS  (0),
    .ACK_TIMEOUT(4)
  ) dut0 (
    .clk_1s  (clk_1s),
    .reset   (reset),
    .start   (start0),
    .pause   (pause0),
    .ack_tgl (ack0),
    .req_tgl (req0),
    .tok_data(data0),
    .tok_cmd (cmd0),
    .busy    (busy0),
    .done    (done0),
    .err     (err0),
    .idx     (idx0)
  );

  script_player #(
    .SCRIPT_LEN (32),
    .GAP_TICKS  (2),
    .ACK_TIMEOUT(4)
  ) dutg (
    .clk_1s  (clk_1s),
    .reset   (reset),
    .start   (startg),
    .pause   (pauseg),
    .ack_tgl (ackg),
    .req_tgl (reqg),
    .tok_data(datag),
    .tok_cmd (cmdg),
    .busy    (busyg),
    .done    (doneg),
    .err     (errg),
    .idx     (idxg)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  int   tcnt  = 0;
  bit   echo0 = 1'b0;
  bit   echog = 1'b0;
  bit   flip0 = 1'b0;
  bit   flipg = 1'b0;
  logic prev0 = 1'b0;
  logic prevg = 1'b0;

  int         exp_d [11] = '{53, 9, 4, 59, 56, 59, 58, 24, 60, 24, 0};
  int         ft [$];
  logic [5:0] fd [$];
  logic [7:0] fc [$];
  logic [4:0] fi [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clk_1s period; the consumer model echoes req back on ack
  task automatic tick();
    @(posedge clk_1s);
    @(negedge clk_1s);
    tcnt++;
    flip0 = (req0 !== prev0);
    prev0 = req0;
    flipg = (reqg !== prevg);
    prevg = reqg;
    if (echo0) ack0 = req0;
    if (echog) ackg = reqg;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    start0 = 1'b0;
    startg = 1'b0;
    pause0 = 1'b0;
    pauseg = 1'b0;
    ack0   = 1'b0;
    ackg   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_flip_g(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!flipg && n < 30);
  endtask

  initial begin
    int t0;
    int n;
    int nf;

    @(negedge clk_1s);
    do_reset();
    check("rst_req", req0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_data", data0, 0);
    check("rst_cmd", cmd0, 0);
    check("rst_idx", idx0, 0);
    check("rst_err", err0, 0);

    // full playback with prompt acks
    echo0 = 1'b1;
    t0 = tcnt;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("busy_after_start", busy0, 1);
    check("no_req_yet", req0, 0);
    for (int k = 0; k < 100 && !done0; k++) begin
      tick();
      if (flip0) begin
        ft.push_back(tcnt);
        fd.push_back(data0);
        fc.push_back(cmd0);
        fi.push_back(idx0);
      end else if (busy0 && fd.size() > 0) begin
        check("data_stable", data0, fd[fd.size()-1]);
      end
    end
    check("flip_count", fd.size(), 11);
    if (ft.size() > 1) begin
      check("first_latency", ft[0] - t0, 2);
      check("token_period", ft[1] - ft[0], 4);
    end
    for (int i = 0; i < 11; i++) begin
      if (i < fd.size()) begin
        check($sformatf("data%0d", i), fd[i], exp_d[i]);
        check($sformatf("cmd%0d", i), fc[i], (i < 10) ? 8'h01 : 8'h11);
        check($sformatf("idx%0d", i), fi[i], i);
      end
    end
    check("end_done", done0, 1);
    check("end_busy", busy0, 0);
    check("end_data", data0, 0);
    check("end_cmd", cmd0, 0);
    check("end_err", err0, 0);
    check("end_idx", idx0, 11);

    // no ack at all: timeout
    echo0 = 1'b0;
    do_reset();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("tmo_flip", req0, 1);
    nf = 0;
    repeat (3) begin
      tick();
      if (flip0) nf++;
    end
    check("tmo_err_early", err0, 0);
    check("tmo_busy", busy0, 1);
    check("tmo_data_hold", data0, 53);
    tick();
    if (flip0) nf++;
    check("tmo_err", err0, 1);
    check("tmo_done", done0, 1);
    check("tmo_busy_off", busy0, 0);
    check("tmo_no_reflip", nf, 0);
    check("tmo_req", req0, 1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("start_clears_err", err0, 0);

    // reset during WAIT_ACK at idx 5
    do_reset();
    echo0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (flip0 && idx0 == 5'd5) break;
    end
    check("mid_idx", idx0, 5);
    check("mid_data", data0, 59);
    echo0 = 1'b0;
    reset = 1'b1;
    ack0  = 1'b0;
    tick();
    reset = 1'b0;
    check("mrst_req", req0, 0);
    check("mrst_data", data0, 0);
    check("mrst_cmd", cmd0, 0);
    check("mrst_busy", busy0, 0);
    check("mrst_done", done0, 0);
    check("mrst_idx", idx0, 0);
    echo0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("replay_req", req0, 1);
    check("replay_data", data0, 53);
    check("replay_idx", idx0, 0);

    // GAP_TICKS=2 instance: pause inside the gap
    echog = 1'b1;
    startg = 1'b1;
    tick();
    startg = 1'b0;
    wait_flip_g(n);
    check("g_latency", n, 1);
    check("g_data0", datag, 53);
    wait_flip_g(n);
    check("g_period", n, 6);
    check("g_data1", datag, 9);
    repeat (3) tick();
    check("g_in_gap_idx", idxg, 2);
    pauseg = 1'b1;
    nf = 0;
    repeat (3) begin
      tick();
      if (flipg) nf++;
    end
    pauseg = 1'b0;
    check("g_pause_noflip", nf, 0);
    check("g_pause_busy", busyg, 1);
    wait_flip_g(n);
    check("g_paused_period", n + 6, 9);
    check("g_data2", datag, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
